// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Avalon-style instruction memory bus between the fetch unit (master) and
// the instruction memory (slave).
//   imem_address     : fetch address, always word aligned    (master -> slave)
//   imem_read        : read request                          (master -> slave)
//   imem_waitrequest : slave not ready, request must be held (slave -> master)
//   imem_readdata    : fetched word, valid when read=1 and waitrequest=0
// ---------------------------------------------------------------------------
interface instr_fetch_if;
   logic [31:0] imem_address;
   logic        imem_read;
   logic        imem_waitrequest;
   logic [31:0] imem_readdata;

   modport master (
      output imem_address,
      output imem_read,
      input  imem_waitrequest,
      input  imem_readdata
   );

   modport slave (
      input  imem_address,
      input  imem_read,
      output imem_waitrequest,
      output imem_readdata
   );
endinterface

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Owns the PC, fetches instructions over the instruction bus, holds the
// fetched word in the instruction register and presents it with its decode
// fields to the decoder. Branch/jump redirects take effect after one delay
// slot. Control transfer to address 0 halts the CPU until reset.
//
// Ports
//   clk              : clock, all state on rising edge
//   reset_n          : synchronous active-low reset
//   imem             : instruction bus (master side)
//   stall            : downstream not ready, hold issued instruction
//   redirect_branch  : issued instruction is a taken branch
//   branch_target    : target for redirect_branch
//   redirect_jump    : issued instruction is a jump (priority over branch)
//   jump_target      : target for redirect_jump
//   instr_valid      : instruction and fields valid this cycle
//   instr            : instruction register
//   opcode           : instr[31:26]
//   function_code    : instr[5:0]
//   b_code           : instr[20:16]
//   pc_out           : PC of the issued instruction
//   pc_plus8         : pc_out + 8 (link address)
//   active           : CPU running, 0 once halted
// ---------------------------------------------------------------------------
module instr_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
   input  logic                clk,
   input  logic                reset_n,
   instr_fetch_if.master       imem,
   input  logic                stall,
   input  logic                redirect_branch,
   input  logic [31:0]         branch_target,
   input  logic                redirect_jump,
   input  logic [31:0]         jump_target,
   output logic                instr_valid,
   output logic [31:0]         instr,
   output logic [5:0]          opcode,
   output logic [5:0]          function_code,
   output logic [4:0]          b_code,
   output logic [31:0]         pc_out,
   output logic [31:0]         pc_plus8,
   output logic                active
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      ISSUE  = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic        delay_pending_q;
   logic [31:0] pending_target_q;
   logic        read_q;
   logic        valid_q;
   logic        active_q;

   logic [31:0] pc_d;
   logic [31:0] jump_target_d;
   logic [31:0] branch_target_d;

   // Next PC on retirement and word-aligned redirect targets.
   always_comb begin
      pc_d            = pc_q + 32'd4;
      jump_target_d   = {jump_target[31:2], 2'b00};
      branch_target_d = {branch_target[31:2], 2'b00};
      if (delay_pending_q) begin
         // Retiring the delay slot: control now moves to the saved target.
         pc_d = pending_target_q;
      end else begin
         pc_d = pc_q + 32'd4;
      end
   end

   // Fetch FSM with registered bus request, valid and active flags.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q          <= IDLE;
         pc_q             <= RESET_VECTOR;
         ir_q             <= 32'd0;
         delay_pending_q  <= 1'b0;
         pending_target_q <= 32'd0;
         read_q           <= 1'b0;
         valid_q          <= 1'b0;
         active_q         <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= FETCH;
               read_q  <= 1'b1;
               valid_q <= 1'b0;
            end
            FETCH: begin
               if (!imem.imem_waitrequest) begin
                  ir_q    <= imem.imem_readdata;
                  state_q <= ISSUE;
                  read_q  <= 1'b0;
                  valid_q <= 1'b1;
               end else begin
                  state_q <= FETCH;
                  read_q  <= 1'b1;
               end
            end
            ISSUE: begin
               if (!stall) begin
                  pc_q    <= pc_d;
                  valid_q <= 1'b0;
                  // Redirects seen in a delay slot are dropped.
                  if (delay_pending_q) begin
                     delay_pending_q <= 1'b0;
                  end else if (redirect_jump) begin
                     pending_target_q <= jump_target_d;
                     delay_pending_q  <= 1'b1;
                  end else if (redirect_branch) begin
                     pending_target_q <= branch_target_d;
                     delay_pending_q  <= 1'b1;
                  end else begin
                     delay_pending_q <= 1'b0;
                  end
                  // Loading PC 0 (jump to 0 or wrap-around) halts the CPU.
                  if (pc_d == 32'd0) begin
                     state_q  <= HALTED;
                     read_q   <= 1'b0;
                     active_q <= 1'b0;
                  end else begin
                     state_q <= FETCH;
                     read_q  <= 1'b1;
                  end
               end else begin
                  state_q <= ISSUE;
               end
            end
            HALTED: begin
               state_q  <= HALTED;
               read_q   <= 1'b0;
               valid_q  <= 1'b0;
               active_q <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               read_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem.imem_address = pc_q;
   assign imem.imem_read    = read_q;

   assign instr_valid   = valid_q;
   assign instr         = ir_q;
   assign opcode        = ir_q[31:26];
   assign function_code = ir_q[5:0];
   assign b_code        = ir_q[20:16];
   assign pc_out        = pc_q;
   assign pc_plus8      = pc_q + 32'd8;
   assign active        = active_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        redirect_branch;
   logic [31:0] branch_target;
   logic        redirect_jump;
   logic [31:0] jump_target;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  function_code;
   logic [4:0]  b_code;
   logic [31:0] pc_out;
   logic [31:0] pc_plus8;
   logic        active;

   int n_checks = 0;
   int n_fail   = 0;

   instr_fetch_if bus ();

   instr_fetch #(.RESET_VECTOR(32'hBFC0_0000)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .imem            (bus.master),
      .stall           (stall),
      .redirect_branch (redirect_branch),
      .branch_target   (branch_target),
      .redirect_jump   (redirect_jump),
      .jump_target     (jump_target),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .opcode          (opcode),
      .function_code   (function_code),
      .b_code          (b_code),
      .pc_out          (pc_out),
      .pc_plus8        (pc_plus8),
      .active          (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n              = 1'b0;
      stall                = 1'b0;
      redirect_branch      = 1'b0;
      branch_target        = 32'd0;
      redirect_jump        = 1'b0;
      jump_target          = 32'd0;
      bus.imem_waitrequest = 1'b0;
      bus.imem_readdata    = 32'h2402_0005;

      // Reset state
      tick();
      tick();
      chk("rst_read",   32'(bus.imem_read), 32'd0);
      chk("rst_valid",  32'(instr_valid),   32'd0);
      chk("rst_instr",  instr,              32'd0);
      chk("rst_opcode", 32'(opcode),        32'd0);
      chk("rst_pc",     pc_out,             32'hBFC0_0000);
      chk("rst_active", 32'(active),        32'd1);

      // Cycle 1 after release is IDLE
      reset_n = 1'b1;
      chk("c1_read", 32'(bus.imem_read), 32'd0);
      tick();
      chk("c2_addr",  bus.imem_address,   32'hBFC0_0000);
      chk("c2_read",  32'(bus.imem_read), 32'd1);
      chk("c2_valid", 32'(instr_valid),   32'd0);
      tick();
      chk("c3_valid",  32'(instr_valid),   32'd1);
      chk("c3_opcode", 32'(opcode),        32'd9);
      chk("c3_bcode",  32'(b_code),        32'd2);
      chk("c3_func",   32'(function_code), 32'd5);
      chk("c3_read",   32'(bus.imem_read), 32'd0);
      chk("c3_pc8",    pc_plus8,           32'hBFC0_0008);
      tick();
      chk("c4_addr", bus.imem_address,   32'hBFC0_0004);
      chk("c4_read", 32'(bus.imem_read), 32'd1);

      // Waitrequest held for 3 FETCH cycles
      bus.imem_waitrequest = 1'b1;
      bus.imem_readdata    = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("ws_addr",  bus.imem_address,   32'hBFC0_0004);
         chk("ws_read",  32'(bus.imem_read), 32'd1);
         chk("ws_valid", 32'(instr_valid),   32'd0);
         chk("ws_ir",    instr,              32'h2402_0005);
      end
      bus.imem_waitrequest = 1'b0;
      bus.imem_readdata    = 32'h0800_0040;
      tick();
      chk("ws_valid_rise", 32'(instr_valid), 32'd1);
      chk("ws_ir_capt",    instr,            32'h0800_0040);
      chk("ws_pc",         pc_out,           32'hBFC0_0004);

      // Jump and branch together at BFC00004: jump wins, target masked
      redirect_jump   = 1'b1;
      jump_target     = 32'hBFC0_0103;
      redirect_branch = 1'b1;
      branch_target   = 32'hBFC0_0200;
      chk("j_pc8", pc_plus8, 32'hBFC0_000C);
      tick();
      redirect_jump   = 1'b0;
      redirect_branch = 1'b0;
      bus.imem_readdata = 32'h1111_2222;
      chk("j_slot_addr", bus.imem_address, 32'hBFC0_0008);
      tick();
      chk("j_slot_pc", pc_out, 32'hBFC0_0008);

      // Stall 4 cycles in the delay slot, with a branch asserted (ignored)
      stall           = 1'b1;
      redirect_branch = 1'b1;
      branch_target   = 32'hBFC0_0300;
      bus.imem_readdata = 32'h3333_4444;
      chk("st_valid", 32'(instr_valid),   32'd1);
      chk("st_instr", instr,              32'h1111_2222);
      chk("st_pc",    pc_out,             32'hBFC0_0008);
      chk("st_read",  32'(bus.imem_read), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_valid", 32'(instr_valid),   32'd1);
         chk("st_instr", instr,              32'h1111_2222);
         chk("st_pc",    pc_out,             32'hBFC0_0008);
         chk("st_read",  32'(bus.imem_read), 32'd0);
      end
      stall = 1'b0;
      tick();
      redirect_branch = 1'b0;
      chk("j_tgt_addr", bus.imem_address, 32'hBFC0_0100);
      tick();
      chk("j_tgt_pc", pc_out, 32'hBFC0_0100);
      tick();
      chk("no_slot_br", bus.imem_address, 32'hBFC0_0104);

      // Jump to 0: delay slot runs, then halt
      tick();
      redirect_jump = 1'b1;
      jump_target   = 32'd0;
      tick();
      redirect_jump = 1'b0;
      chk("h_slot_addr", bus.imem_address, 32'hBFC0_0108);
      chk("h_active1",   32'(active),      32'd1);
      tick();
      chk("h_slot_valid", 32'(instr_valid), 32'd1);
      chk("h_slot_pc",    pc_out,           32'hBFC0_0108);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("h_active", 32'(active),        32'd0);
         chk("h_read",   32'(bus.imem_read), 32'd0);
         chk("h_valid",  32'(instr_valid),   32'd0);
      end

      // Reset restarts at the reset vector
      reset_n = 1'b0;
      tick();
      chk("rr_pc",     pc_out,             32'hBFC0_0000);
      chk("rr_active", 32'(active),        32'd1);
      chk("rr_instr",  instr,              32'd0);
      reset_n = 1'b1;
      chk("rr_idle", 32'(bus.imem_read), 32'd0);
      tick();
      chk("rr_addr", bus.imem_address,   32'hBFC0_0000);
      chk("rr_read", 32'(bus.imem_read), 32'd1);

      // Reset mid-FETCH with waitrequest high
      bus.imem_waitrequest = 1'b1;
      tick();
      chk("mf_read_hold", 32'(bus.imem_read), 32'd1);
      reset_n = 1'b0;
      tick();
      chk("mf_read_drop", 32'(bus.imem_read), 32'd0);
      chk("mf_valid",     32'(instr_valid),   32'd0);
      reset_n = 1'b1;
      chk("mf_idle", 32'(bus.imem_read), 32'd0);
      tick();
      chk("mf_addr", bus.imem_address,   32'hBFC0_0000);
      chk("mf_read", 32'(bus.imem_read), 32'd1);
      bus.imem_waitrequest = 1'b0;
      bus.imem_readdata    = 32'h03E0_0008;
      tick();
      chk("mf_ir", instr, 32'h03E0_0008);

      // Wrap-around: run up to FFFFFFFC, PC+4 wraps to 0 and halts
      redirect_jump = 1'b1;
      jump_target   = 32'hFFFF_FFF8;
      tick();
      redirect_jump = 1'b0;
      chk("w_slot_addr", bus.imem_address, 32'hBFC0_0004);
      tick();
      tick();
      chk("w_addr0", bus.imem_address, 32'hFFFF_FFF8);
      tick();
      tick();
      chk("w_addr1", bus.imem_address, 32'hFFFF_FFFC);
      tick();
      chk("w_pc8",    pc_plus8,    32'h0000_0004);
      chk("w_active", 32'(active), 32'd1);
      tick();
      chk("w_halt", 32'(active),        32'd0);
      chk("w_read", 32'(bus.imem_read), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
